// File: rtl/iguana_pkg.sv
// Shared definitions for the iguana USB pin-mux controller.
//   UsbNumPorts    - default number of USB ports (each owns pads {2p+1 = dp, 2p = dm})
//   UsbGuardCycles - default tri-state guard length between pad owners
//   UsbGuardCntW   - guard counter width (guard lengths 1..255)
//   usb_pm_state_e - per-port ownership state
package iguana_pkg;

    localparam int UsbNumPorts    = 4;
    localparam int UsbGuardCycles = 8;
    localparam int UsbGuardCntW   = 8;

    typedef enum logic [1:0] {
        USB_PM_GPIO = 2'd0,
        USB_PM_G2U  = 2'd1,
        USB_PM_USB  = 2'd2,
        USB_PM_U2G  = 2'd3
    } usb_pm_state_e;

    function automatic logic is_guard(usb_pm_state_e s);
        return (s == USB_PM_G2U) || (s == USB_PM_U2G);
    endfunction

endpackage

// File: rtl/iguana_usb_pinmux_port.sv
// One USB port's pad ownership FSM, guard counter and pad mux.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   usb_en_req_i          request USB ownership of this port's pads
//   pad_i/pad_o/pad_en_o  pad pair {dp, dm}
//   gpio_o_i/gpio_en_i    GPIO core drive for the pad pair
//   usb_d{m,p}_o_i/_oe_i  USB core drive and enables
//   usb_d{m,p}_i_o        line values to USB core (idle J when not owned)
//   usb_active_o          port is owned by USB
//   switching_o           port is in a tri-state guard
//
// state | meaning
// GPIO  | pads driven by GPIO core
// G2U   | guard, all enables off, heading to USB
// USB   | pads driven by USB core
// U2G   | guard, all enables off, heading to GPIO
module iguana_usb_pinmux_port
    import iguana_pkg::*;
#(
    parameter int GuardCycles = UsbGuardCycles
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       usb_en_req_i,
    input  logic [1:0] pad_i,
    output logic [1:0] pad_o,
    output logic [1:0] pad_en_o,
    input  logic [1:0] gpio_o_i,
    input  logic [1:0] gpio_en_i,
    input  logic       usb_dm_o_i,
    input  logic       usb_dp_o_i,
    input  logic       usb_dm_oe_i,
    input  logic       usb_dp_oe_i,
    output logic       usb_dm_i_o,
    output logic       usb_dp_i_o,
    output logic       usb_active_o,
    output logic       switching_o
);

    localparam logic [UsbGuardCntW-1:0] GuardLoad = UsbGuardCntW'(GuardCycles - 1);

    usb_pm_state_e             state_q, state_d;
    logic [UsbGuardCntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= USB_PM_GPIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            USB_PM_GPIO: begin
                if (usb_en_req_i) begin
                    state_d = USB_PM_G2U;
                    cnt_d   = GuardLoad;
                end
            end
            USB_PM_G2U: begin
                // An abort restarts a full guard rather than reusing the remainder.
                if (!usb_en_req_i) begin
                    state_d = USB_PM_U2G;
                    cnt_d   = GuardLoad;
                end else if (cnt_q == '0) begin
                    state_d = USB_PM_USB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            USB_PM_USB: begin
                if (!usb_en_req_i) begin
                    state_d = USB_PM_U2G;
                    cnt_d   = GuardLoad;
                end
            end
            USB_PM_U2G: begin
                // Request is ignored here; it is re-evaluated once back in GPIO.
                if (cnt_q == '0) begin
                    state_d = USB_PM_GPIO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = USB_PM_GPIO;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pad_o        = gpio_o_i;
        pad_en_o     = gpio_en_i;
        usb_dm_i_o   = 1'b0;
        usb_dp_i_o   = 1'b1;
        usb_active_o = 1'b0;
        switching_o  = is_guard(state_q);
        if (state_q == USB_PM_USB) begin
            pad_o        = {usb_dp_o_i, usb_dm_o_i};
            pad_en_o     = {usb_dp_oe_i, usb_dm_oe_i};
            usb_dm_i_o   = pad_i[0];
            usb_dp_i_o   = pad_i[1];
            usb_active_o = 1'b1;
        end else if (is_guard(state_q)) begin
            pad_o    = 2'b00;
            pad_en_o = 2'b00;
        end
    end

endmodule

// File: rtl/iguana_usb_pinmux_ctrl.sv
// USB / GPIO pad ownership controller: one independent guard FSM per port.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   usb_en_req_i[NumPorts]  per-port USB ownership request
//   pad_i/pad_o/pad_en_o    pads, pair p = {2p+1 dp, 2p dm}
//   gpio_o_i/gpio_en_i      GPIO core drive; gpio_i_o is always the raw pad value
//   usb_d{m,p}_*            USB core drive/enables and received line values
//   usb_active_o            port owned by USB
//   switching_o             port in a guard
module iguana_usb_pinmux_ctrl
    import iguana_pkg::*;
#(
    parameter int NumPorts    = UsbNumPorts,
    parameter int GuardCycles = UsbGuardCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumPorts-1:0]   usb_en_req_i,
    input  logic [2*NumPorts-1:0] pad_i,
    output logic [2*NumPorts-1:0] pad_o,
    output logic [2*NumPorts-1:0] pad_en_o,
    input  logic [2*NumPorts-1:0] gpio_o_i,
    input  logic [2*NumPorts-1:0] gpio_en_i,
    output logic [2*NumPorts-1:0] gpio_i_o,
    input  logic [NumPorts-1:0]   usb_dm_o_i,
    input  logic [NumPorts-1:0]   usb_dp_o_i,
    input  logic [NumPorts-1:0]   usb_dm_oe_i,
    input  logic [NumPorts-1:0]   usb_dp_oe_i,
    output logic [NumPorts-1:0]   usb_dm_i_o,
    output logic [NumPorts-1:0]   usb_dp_i_o,
    output logic [NumPorts-1:0]   usb_active_o,
    output logic [NumPorts-1:0]   switching_o
);

    if (GuardCycles < 1 || GuardCycles > 255) begin : g_bad_guard
        $fatal(1, "iguana_usb_pinmux_ctrl: GuardCycles=%0d outside 1..255", GuardCycles);
    end

    assign gpio_i_o = pad_i;

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        iguana_usb_pinmux_port #(
            .GuardCycles(GuardCycles)
        ) u_port (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .usb_en_req_i (usb_en_req_i[p]),
            .pad_i        (pad_i[2*p+1:2*p]),
            .pad_o        (pad_o[2*p+1:2*p]),
            .pad_en_o     (pad_en_o[2*p+1:2*p]),
            .gpio_o_i     (gpio_o_i[2*p+1:2*p]),
            .gpio_en_i    (gpio_en_i[2*p+1:2*p]),
            .usb_dm_o_i   (usb_dm_o_i[p]),
            .usb_dp_o_i   (usb_dp_o_i[p]),
            .usb_dm_oe_i  (usb_dm_oe_i[p]),
            .usb_dp_oe_i  (usb_dp_oe_i[p]),
            .usb_dm_i_o   (usb_dm_i_o[p]),
            .usb_dp_i_o   (usb_dp_i_o[p]),
            .usb_active_o (usb_active_o[p]),
            .switching_o  (switching_o[p])
        );
    end

endmodule

// File: tb/tb_iguana_usb_pinmux_ctrl.sv
module tb_iguana_usb_pinmux_ctrl;
    import iguana_pkg::*;

    localparam int NP = 4;
    localparam int G  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req;
    logic [2*NP-1:0] pad_i, pad_o, pad_en, gpio_o, gpio_en, gpio_i;
    logic [NP-1:0]   dm_o, dp_o, dm_oe, dp_oe, dm_i, dp_i, act, sw;

    always #5 clk = ~clk;

    iguana_usb_pinmux_ctrl #(.NumPorts(NP), .GuardCycles(G)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .usb_en_req_i (req),
        .pad_i        (pad_i),
        .pad_o        (pad_o),
        .pad_en_o     (pad_en),
        .gpio_o_i     (gpio_o),
        .gpio_en_i    (gpio_en),
        .gpio_i_o     (gpio_i),
        .usb_dm_o_i   (dm_o),
        .usb_dp_o_i   (dp_o),
        .usb_dm_oe_i  (dm_oe),
        .usb_dp_oe_i  (dp_oe),
        .usb_dm_i_o   (dm_i),
        .usb_dp_i_o   (dp_i),
        .usb_active_o (act),
        .switching_o  (sw)
    );

    typedef struct packed {
        logic [2*NP-1:0] pad_o;
        logic [2*NP-1:0] pad_en;
        logic [2*NP-1:0] gpio_i;
        logic [NP-1:0]   dm;
        logic [NP-1:0]   dp;
        logic [NP-1:0]   act;
        logic [NP-1:0]   sw;
    } exp_t;

    typedef enum int {M_GPIO, M_TO_USB, M_USB, M_TO_GPIO} mmode_e;

    exp_t   sb_q[$];
    int     grant_q[NP][$];
    mmode_e m_mode[NP];
    int     m_rem[NP];
    int     run[NP];
    logic [NP-1:0] prev_act = '0;
    int     checks = 0;
    int     errors = 0;
    int     cycle  = 0;

    // Reference: m_rem is the number of guard cycles still to spend, including the current one.
    task automatic model_edge();
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                m_mode[p] = M_GPIO;
                m_rem[p]  = 0;
                grant_q[p].delete();
            end else begin
                case (m_mode[p])
                    M_GPIO: if (req[p]) begin
                        m_mode[p] = M_TO_USB;
                        m_rem[p]  = G;
                        grant_q[p].push_back(cycle + G);
                    end
                    M_TO_USB: if (!req[p]) begin
                        m_mode[p] = M_TO_GPIO;
                        m_rem[p]  = G;
                        void'(grant_q[p].pop_back());
                    end else if (m_rem[p] == 1) m_mode[p] = M_USB;
                    else m_rem[p]--;
                    M_USB: if (!req[p]) begin
                        m_mode[p] = M_TO_GPIO;
                        m_rem[p]  = G;
                    end
                    M_TO_GPIO: if (m_rem[p] == 1) m_mode[p] = M_GPIO;
                    else m_rem[p]--;
                    default: m_mode[p] = M_GPIO;
                endcase
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gpio_i = pad_i;
        for (int p = 0; p < NP; p++) begin
            e.act[p] = 1'b0;
            e.sw[p]  = 1'b0;
            e.dm[p]  = 1'b0;
            e.dp[p]  = 1'b1;
            case (m_mode[p])
                M_GPIO: begin
                    e.pad_o[2*p+:2]  = gpio_o[2*p+:2];
                    e.pad_en[2*p+:2] = gpio_en[2*p+:2];
                end
                M_USB: begin
                    e.pad_o[2*p+:2]  = {dp_o[p], dm_o[p]};
                    e.pad_en[2*p+:2] = {dp_oe[p], dm_oe[p]};
                    e.dm[p]  = pad_i[2*p];
                    e.dp[p]  = pad_i[2*p+1];
                    e.act[p] = 1'b1;
                end
                default: begin
                    e.pad_o[2*p+:2]  = 2'b00;
                    e.pad_en[2*p+:2] = 2'b00;
                    e.sw[p] = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cycle, got, exp);
        end
    endtask

    task automatic compare_cycle();
        exp_t got, e;
        got = '{pad_o: pad_o, pad_en: pad_en, gpio_i: gpio_i, dm: dm_i, dp: dp_i, act: act, sw: sw};
        e = sb_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL outputs cycle %0d observed %h expected %h", cycle, got, e);
        end
        for (int p = 0; p < NP; p++) begin
            if (act[p] && !prev_act[p]) begin
                checks++;
                if (grant_q[p].size() == 0) begin
                    errors++;
                    $error("FAIL grant_unexpected port %0d cycle %0d observed 1 expected 0", p, cycle);
                end else begin
                    int exp_c;
                    exp_c = grant_q[p].pop_front();
                    assert (cycle == exp_c) else begin
                        errors++;
                        $error("FAIL grant_cycle port %0d observed %0d expected %0d", p, cycle, exp_c);
                    end
                end
            end
            if (rst) run[p] = 0;
            else if (sw[p]) run[p]++;
            else begin
                if (run[p] > 0) begin
                    checks++;
                    assert (run[p] >= G) else begin
                        errors++;
                        $error("FAIL guard_len port %0d observed %0d expected >=%0d", p, run[p], G);
                    end
                end
                run[p] = 0;
            end
        end
        prev_act = act;
    endtask

    task automatic cyc();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        pad_i   = 8'($urandom);
        gpio_o  = 8'($urandom);
        gpio_en = 8'($urandom);
        dm_o    = 4'($urandom);
        dp_o    = 4'($urandom);
        dm_oe   = 4'($urandom);
        dp_oe   = 4'($urandom);
        sb_q.push_back(model_out());
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_act"}, 32'(act), 32'h0);
        chk({tag, "_sw"}, 32'(sw), 32'h0);
        chk({tag, "_pad_en"}, 32'(pad_en), 32'(gpio_en));
        chk({tag, "_pad_o"}, 32'(pad_o), 32'(gpio_o));
        chk({tag, "_dm"}, 32'(dm_i), 32'h0);
        chk({tag, "_dp"}, 32'(dp_i), 32'hF);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            m_mode[p] = M_GPIO;
            m_rem[p]  = 0;
            run[p]    = 0;
        end
        rst = 1'b1;
        req = '0;
        pad_i = '0; gpio_o = '0; gpio_en = '0;
        dm_o = '0; dp_o = '0; dm_oe = '0; dp_oe = '0;
        repeat (3) cyc();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Port 0 request at cycle 10: guard cycles 11..18, USB at 19.
        while (cycle < 10) cyc();
        req = 4'b0001;
        for (int i = 0; i < G; i++) begin
            cyc();
            chk("p0_guard_en", 32'(pad_en[1:0]), 32'h0);
            chk("p0_guard_act", 32'(act[0]), 32'h0);
        end
        cyc();
        chk("p0_grant_cycle", 32'(cycle), 32'd19);
        chk("p0_active", 32'(act), 32'h1);
        chk("p0_others_en", 32'(pad_en[7:2]), 32'(gpio_en[7:2]));
        repeat (3) cyc();

        // Release port 0: full guard with idle J, then GPIO drive back.
        req = 4'b0000;
        for (int i = 0; i < G; i++) begin
            cyc();
            chk("p0_rel_sw", 32'(sw[0]), 32'h1);
            chk("p0_rel_dp", 32'(dp_i[0]), 32'h1);
            chk("p0_rel_dm", 32'(dm_i[0]), 32'h0);
        end
        cyc();
        chk("p0_gpio_back_sw", 32'(sw[0]), 32'h0);
        chk("p0_gpio_back_en", 32'(pad_en[1:0]), 32'(gpio_en[1:0]));

        // Port 2: abort when the guard counter is at 3, re-request during U2G, drop again.
        req = 4'b0100;
        repeat (5) cyc();
        req = 4'b0000;
        cyc();
        req = 4'b0100;
        repeat (4) begin
            cyc();
            chk("p2_abort_act", 32'(act[2]), 32'h0);
        end
        req = 4'b0000;
        repeat (G + 2) begin
            cyc();
            chk("p2_abort_act", 32'(act[2]), 32'h0);
        end
        chk("p2_back_gpio_sw", 32'(sw[2]), 32'h0);

        // All ports at once.
        req = 4'b1111;
        repeat (G) cyc();
        chk("all_guard_act", 32'(act), 32'h0);
        cyc();
        chk("all_active", 32'(act), 32'hF);
        for (int p = 0; p < NP; p++)
            chk("all_pad_en", 32'(pad_en[2*p+:2]), 32'({dp_oe[p], dm_oe[p]}));
        req = 4'b0000;
        repeat (G + 2) cyc();

        // Reset during G2U, then during USB.
        req = 4'b0010;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        check_reset_outputs("rst_g2u");
        rst = 1'b0;
        repeat (G + 3) cyc();
        chk("p1_usb_before_rst", 32'(act[1]), 32'h1);
        rst = 1'b1;
        cyc();
        check_reset_outputs("rst_usb");
        rst = 1'b0;
        req = 4'b0000;
        repeat (G + 2) cyc();

        // Random requests; the per-cycle model, grant queue and guard length checks run throughout.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 11) == 0) req[p] = ~req[p];
            cyc();
        end
        req = 4'b0000;
        repeat (G + 2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle %0d observed running expected finished", cycle);
        $fatal(1, "timeout");
    end

endmodule
